median_window_reader: RTL

Read-side sequencer for the median-filter frame buffer. Once a frame has been written into the pixel RAM in raster order, this block walks every output pixel position in raster order. For each position it fetches the 3x3 neighbourhood from the RAM and replicates edge pixels at the image borders. It then presents the nine pixels as one packed window to the median core over a valid/ready handshake.

---
 rtl/median_window_reader.sv | 142 ++++++++++++++
 1 files changed

// File: rtl/median_window_reader.sv
// Read-side sequencer for the median-filter frame buffer: walks every pixel in raster order,
// fetches its 3x3 neighbourhood (edges replicated) and offers it to the median core.
module median_window_reader #(
    parameter int IMG_W  = 32,
    parameter int IMG_H  = 32,
    parameter int ADDR_W = 10,
    parameter int PIX_W  = 8,
    localparam int XW    = $clog2(IMG_W),
    localparam int YW    = $clog2(IMG_H)
) (
    input  logic                 CLK,
    input  logic                 RST,
    input  logic                 start_i,
    output logic                 busy_o,
    output logic                 done_o,
    output logic                 rd_en_o,
    output logic [ADDR_W-1:0]    rd_addr_o,
    input  logic [PIX_W-1:0]     rd_data_i,
    output logic [9*PIX_W-1:0]   win_o,
    output logic                 win_valid_o,
    input  logic                 win_ready_i,
    output logic [XW-1:0]        pix_x_o,
    output logic [YW-1:0]        pix_y_o,
    output logic [2:0]           dbg_state_o
);

    typedef enum logic [2:0] {
        S_IDLE    = 3'd0,
        S_FETCH   = 3'd1,
        S_CAPTURE = 3'd2,
        S_PRESENT = 3'd3,
        S_DONE    = 3'd4
    } state_t;

    state_t state, state_nxt;

    logic [3:0]        k;
    logic [XW-1:0]     x;
    logic [YW-1:0]     y;
    logic [PIX_W-1:0]  win_q [9];

    logic [1:0]        tap_row, tap_col;
    logic [XW-1:0]     cx;
    logic [YW-1:0]     cy;
    logic [ADDR_W-1:0] tap_addr;
    logic              last_x, last_y, xfer;

    assign last_x = (x == XW'(IMG_W - 1));
    assign last_y = (y == YW'(IMG_H - 1));
    // Window handshake: a transfer happens on a rising edge where win_valid_o and
    // win_ready_i are both high; until then win_o/pix_x_o/pix_y_o do not change.
    assign xfer   = (state == S_PRESENT) && win_ready_i;

    always_ff @(posedge CLK) begin
        if (RST) begin
            state <= S_IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        case (state)
            S_IDLE:    if (start_i) state_nxt = S_FETCH;
            S_FETCH:   if (k == 4'd8) state_nxt = S_CAPTURE;
            S_CAPTURE: state_nxt = S_PRESENT;
            S_PRESENT: if (win_ready_i) state_nxt = (last_x && last_y) ? S_DONE : S_FETCH;
            S_DONE:    state_nxt = S_IDLE;
            default:   state_nxt = S_IDLE;
        endcase
    end

    always_comb begin
        busy_o      = (state != S_IDLE);
        done_o      = (state == S_DONE);
        rd_en_o     = (state == S_FETCH);
        win_valid_o = (state == S_PRESENT);
        rd_addr_o   = (state == S_FETCH) ? tap_addr : '0;
        dbg_state_o = state;
    end

    // Tap k sits at row k/3 and column k%3 of the neighbourhood; clamp at the borders.
    always_comb begin
        case (k)
            4'd0, 4'd1, 4'd2: tap_row = 2'd0;
            4'd3, 4'd4, 4'd5: tap_row = 2'd1;
            default:          tap_row = 2'd2;
        endcase
        case (k)
            4'd0, 4'd3, 4'd6: tap_col = 2'd0;
            4'd1, 4'd4, 4'd7: tap_col = 2'd1;
            default:          tap_col = 2'd2;
        endcase
        cy = y;
        cx = x;
        if (tap_row == 2'd0 && y != '0) cy = y - YW'(1);
        if (tap_row == 2'd2 && !last_y) cy = y + YW'(1);
        if (tap_col == 2'd0 && x != '0) cx = x - XW'(1);
        if (tap_col == 2'd2 && !last_x) cx = x + XW'(1);
        tap_addr = ADDR_W'(cy) * ADDR_W'(IMG_W) + ADDR_W'(cx);
    end

    always_ff @(posedge CLK) begin
        if (RST) begin
            k <= '0;
            x <= '0;
            y <= '0;
            for (int i = 0; i < 9; i++) win_q[i] <= '0;
        end else begin
            if (state != S_FETCH) k <= '0;
            case (state)
                S_FETCH: begin
                    k <= k + 4'd1;
                    // Read data lags the strobe by one cycle, so it belongs to the previous tap.
                    if (k != 4'd0) win_q[k - 4'd1] <= rd_data_i;
                end
                S_CAPTURE: win_q[8] <= rd_data_i;
                S_PRESENT: begin
                    if (xfer) begin
                        if (last_x) begin
                            x <= '0;
                            y <= last_y ? '0 : y + YW'(1);
                        end else begin
                            x <= x + XW'(1);
                        end
                    end
                end
                default: ;
            endcase
        end
    end

    always_comb begin
        win_o = '0;
        for (int i = 0; i < 9; i++) win_o[PIX_W*i +: PIX_W] = win_q[i];
    end

    assign pix_x_o = x;
    assign pix_y_o = y;

endmodule
